mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: LINE_W, 256, line width in bits; ADDR_W, 32, byte-address width.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset; asynchronous, active-low.
REQ-004 pN_enable_i  input  1  request from port N (N=0 instruction side, N=1 data side).
REQ-005 pN_write_i  input  1  port N request is a write (1) or read (0).
REQ-006 pN_addr_i  input  ADDR_W  port N byte address.
REQ-007 pN_data_i  input  LINE_W  port N write line.
REQ-008 pN_ack_o  output  1  one-cycle completion pulse to port N.
REQ-009 pN_data_o  output  LINE_W  port N read line; valid while pN_ack_o=1, held until port N's next read completes.
REQ-010 mem_enable_o, mem_write_o  output  1 each; mem_addr_o  output  ADDR_W; mem_data_o  output  LINE_W  drive the shared line memory.
REQ-011 mem_ack_i  input  1; mem_data_i  input  LINE_W  memory completion and read line; read line valid the cycle after mem_ack_i.
REQ-012 busy_o  output  1  high in every state except IDLE; grant_o  output  1  port owning the current transaction.

Function
REQ-013 FSM states SHALL be IDLE, BUSY, CAPT, RESP.
REQ-014 IDLE: no request -> stay; one request -> grant it; both -> grant port rr; transition to BUSY on the same edge.
REQ-015 At the grant edge, write flag, address and write line of the granted port SHALL be latched; mem_* outputs come only from these latches and stay stable until IDLE.
REQ-016 mem_enable_o SHALL be 1 only in BUSY; mem_write_o, mem_addr_o, mem_data_o reflect the latches in BUSY and CAPT.
REQ-017 BUSY: stay until mem_ack_i=1, then CAPT; enable therefore drops the cycle after ack, so the memory starts no second transaction.
REQ-018 CAPT (one cycle): on a read, load mem_data_i into the granted port's data register; on a write, leave it unchanged; go to RESP.
REQ-019 RESP (one cycle): pN_ack_o=1 for the granted port only; go to IDLE.
REQ-020 The other port's ack SHALL never assert and its data register SHALL not change during that transaction.
REQ-021 Round-robin pointer rr SHALL update at each grant to the port not granted; reset value 0.
REQ-022 Latency: request first seen in IDLE at cycle 0 with memory ack in cycle k -> ack pulse in cycle k+2; with the 8-wait memory, k=9 and ack is in cycle 11.
REQ-023 IDLE SHALL not sample requests in the RESP cycle, so a port holding enable through its ack pulse is not re-granted; requests seen in IDLE the cycle after RESP are new requests.
REQ-024 mem_ack_i outside BUSY SHALL be ignored.
REQ-025 A port dropping enable before its ack SHALL still get its transaction completed and acked.
REQ-026 Ports SHALL hold enable, write, addr and data stable from assertion until their ack pulse, and drop enable the cycle after ack unless issuing a new request.

Reset
REQ-027 While rst_i=0: state=IDLE, rr=0, grant_o=0, latches=0, pN_ack_o=0, pN_data_o=0, mem_enable_o=0, mem_write_o=0, busy_o=0.
REQ-028 Reset mid-transaction SHALL abort it with no ack; the memory shares rst_i and aborts too. The first grant after release follows REQ-014 with rr=0.

Verification
REQ-029 Port 0 read addr 0x40, memory line 0xA5..A5 -> mem_enable_o cycles 1-9, p0_ack_o in cycle 11 only, p0_data_o=0xA5..A5, p1 signals unchanged.
REQ-030 Port 1 write addr 0x80, data 0x1234 -> mem_write_o=1 and mem_addr_o=0x80 through BUSY, p1_ack_o in cycle 11; a following port 1 read of 0x80 returns 0x1234.
REQ-031 Both ports request in the same cycle after reset -> port 0 served first (ack cycle 11), port 1 granted in cycle 12, ack cycle 23.
REQ-032 Both ports hold requests continuously for 4 transactions -> grants alternate 0,1,0,1; no port acked twice in a row.
REQ-033 rst_i low in cycle 5 of a port 0 read, released in cycle 7 -> no p0_ack_o, all outputs at reset values; new port 1 request granted immediately with normal 11-cycle latency.
REQ-034 Spurious mem_ack_i pulse in IDLE, plus port 0 holding enable through its ack cycle -> no state change, no duplicate grant.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter in front of a shared line memory
//
// Purpose: serialises line requests from an instruction port (0) and a data
// port (1) onto one memory interface. One transaction at a time walks
// IDLE -> BUSY -> CAPT -> RESP -> IDLE.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   pN_enable_i/pN_write_i       port N request strobe and direction
//   pN_addr_i/pN_data_i          port N byte address and write line
//   pN_ack_o/pN_data_o           port N completion pulse and read line register
//   mem_enable_o/mem_write_o     memory request strobe and direction
//   mem_addr_o/mem_data_o        memory address and write line (from grant latches)
//   mem_ack_i/mem_data_i         memory completion, read line (valid cycle after ack)
//   busy_o, grant_o              not-IDLE flag, port owning current transaction

module mem_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p0_enable_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [LINE_W-1:0] p0_data_i,
    output logic              p0_ack_o,
    output logic [LINE_W-1:0] p0_data_o,
    input  logic              p1_enable_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [LINE_W-1:0] p1_data_i,
    output logic              p1_ack_o,
    output logic [LINE_W-1:0] p1_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic              busy_o,
    output logic              grant_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              rr_q, rr_d;
    logic              grant_q, grant_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] p0_data_q, p0_data_d;
    logic [LINE_W-1:0] p1_data_q, p1_data_d;
    logic              gnt;

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        grant_d   = grant_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        p0_data_d = p0_data_q;
        p1_data_d = p1_data_q;
        gnt       = 1'b0;

        case (state_q)
            IDLE: begin
                if (p0_enable_i || p1_enable_i) begin
                    // Contention goes to rr; otherwise whichever port is asking.
                    gnt     = (p0_enable_i && p1_enable_i) ? rr_q : p1_enable_i;
                    grant_d = gnt;
                    rr_d    = ~gnt;
                    wr_d    = gnt ? p1_write_i : p0_write_i;
                    addr_d  = gnt ? p1_addr_i  : p0_addr_i;
                    wdata_d = gnt ? p1_data_i  : p0_data_i;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                // Memory presents the read line one cycle after its ack.
                if (!wr_q) begin
                    if (grant_q) begin
                        p1_data_d = mem_data_i;
                    end else begin
                        p0_data_d = mem_data_i;
                    end
                end
                state_d = RESP;
            end
            RESP: begin
                // Straight back to IDLE without sampling requests, so a port
                // still holding enable during its ack is not served twice.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            grant_q   <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            p0_data_q <= '0;
            p1_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            grant_q   <= grant_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            p0_data_q <= p0_data_d;
            p1_data_q <= p1_data_d;
        end
    end

    assign mem_enable_o = (state_q == BUSY);
    assign mem_write_o  = wr_q && ((state_q == BUSY) || (state_q == CAPT));
    assign mem_addr_o   = addr_q;
    assign mem_data_o   = wdata_q;
    assign busy_o       = (state_q != IDLE);
    assign grant_o      = grant_q;
    assign p0_ack_o     = (state_q == RESP) && !grant_q;
    assign p1_ack_o     = (state_q == RESP) && grant_q;
    assign p0_data_o    = p0_data_q;
    assign p1_data_o    = p1_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with an 8-wait memory model
module tb_mem_arbiter;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_i = 1'b0;
    logic              p0_enable_i = 1'b0, p0_write_i = 1'b0;
    logic [ADDR_W-1:0] p0_addr_i = '0;
    logic [LINE_W-1:0] p0_data_i = '0;
    logic              p0_ack_o;
    logic [LINE_W-1:0] p0_data_o;
    logic              p1_enable_i = 1'b0, p1_write_i = 1'b0;
    logic [ADDR_W-1:0] p1_addr_i = '0;
    logic [LINE_W-1:0] p1_data_i = '0;
    logic              p1_ack_o;
    logic [LINE_W-1:0] p1_data_o;
    logic              mem_enable_o, mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic              mem_ack_i;
    logic [LINE_W-1:0] mem_data_i;
    logic              busy_o, grant_o;

    mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .p0_enable_i(p0_enable_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i),
        .p0_data_i(p0_data_i), .p0_ack_o(p0_ack_o), .p0_data_o(p0_data_o),
        .p1_enable_i(p1_enable_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
        .p1_data_i(p1_data_i), .p1_ack_o(p1_ack_o), .p1_data_o(p1_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .busy_o(busy_o), .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 8-wait memory: enable seen 8 cycles, ack in the 9th, line valid the cycle after.
    logic [LINE_W-1:0] mem_store [logic [ADDR_W-1:0]];
    logic              ack_q = 1'b0;
    logic              spur = 1'b0;
    int                wcnt = 0;
    logic [LINE_W-1:0] rdata_q = '0;
    assign mem_ack_i  = ack_q | spur;
    assign mem_data_i = rdata_q;

    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            ack_q <= 1'b0;
            wcnt  <= 0;
        end else if (mem_enable_o && !ack_q) begin
            if (wcnt == 7) begin
                ack_q <= 1'b1;
                wcnt  <= 0;
                if (mem_write_o) mem_store[mem_addr_o] = mem_data_o;
                else rdata_q <= mem_store.exists(mem_addr_o) ? mem_store[mem_addr_o] : '0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            ack_q <= 1'b0;
            wcnt  <= 0;
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int                port;
        bit                wr;
        logic [LINE_W-1:0] data;
        int                cyc;
    } exp_t;
    exp_t exp_q[$];

    logic [LINE_W-1:0] hold0 = '0, hold1 = '0;

    // Monitor: every ack pops the next expected transaction.
    always @(negedge clk) begin
        if (!rst_i) begin
            hold0 = '0;
            hold1 = '0;
        end else if (p0_ack_o || p1_ack_o) begin
            exp_t e;
            int   ap;
            ap = p1_ack_o ? 1 : 0;
            if (p0_ack_o && p1_ack_o) check("dual_ack", 1, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_ack_port", ap, 99);
            end else begin
                e = exp_q.pop_front();
                check("ack_port", ap, e.port);
                check("ack_cycle", cyc, e.cyc);
                if (!e.wr) begin
                    if (e.port == 1) hold1 = e.data;
                    else hold0 = e.data;
                end
                check("p0_data", p0_data_o, hold0);
                check("p1_data", p1_data_o, hold1);
            end
        end
    end

    task automatic run_txn(input int port, input logic wr, input logic [ADDR_W-1:0] addr,
                           input logic [LINE_W-1:0] wdata, input logic [LINE_W-1:0] exp_rd);
        int en_cnt = 0;
        int bad = 0;
        bit got = 0;
        @(negedge clk);
        if (port == 0) begin
            p0_enable_i = 1; p0_write_i = wr; p0_addr_i = addr; p0_data_i = wdata;
        end else begin
            p1_enable_i = 1; p1_write_i = wr; p1_addr_i = addr; p1_data_i = wdata;
        end
        exp_q.push_back('{port, wr, exp_rd, cyc + 11});
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_enable_o) begin
                en_cnt++;
                if (mem_write_o !== wr || mem_addr_o !== addr || (wr && mem_data_o !== wdata)) bad++;
            end
            if ((port == 0 && p0_ack_o) || (port == 1 && p1_ack_o)) begin
                got = 1;
                break;
            end
        end
        @(negedge clk);
        p0_enable_i = 0;
        p1_enable_i = 0;
        check("txn_done", got, 1);
        check("enable_cycles", en_cnt, 9);
        check("mem_fields", bad, 0);
    endtask

    initial begin
        int c, n0, n1;
        logic [LINE_W-1:0] a5, w1234;
        a5    = {32{8'hA5}};
        w1234 = 256'h1234;
        mem_store[32'h40] = a5;

        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_grant", grant_o, 0);
        check("rst_acks", {p0_ack_o, p1_ack_o}, 0);
        check("rst_p0_data", p0_data_o, 0);
        check("rst_p1_data", p1_data_o, 0);
        check("rst_mem_en_wr", {mem_enable_o, mem_write_o}, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        rst_i = 1;

        // Port 0 read, port 1 write then read back.
        run_txn(0, 0, 32'h40, '0, a5);
        run_txn(1, 1, 32'h80, w1234, '0);
        run_txn(1, 0, 32'h80, '0, w1234);

        // Fresh reset, then both ports hold requests for four transactions.
        @(negedge clk); rst_i = 0;
        repeat (2) @(negedge clk); rst_i = 1;
        @(negedge clk);
        c = cyc;
        p0_enable_i = 1; p0_write_i = 0; p0_addr_i = 32'h40;
        p1_enable_i = 1; p1_write_i = 0; p1_addr_i = 32'h80;
        exp_q.push_back('{0, 0, a5, c + 11});
        exp_q.push_back('{1, 0, w1234, c + 23});
        exp_q.push_back('{0, 0, a5, c + 35});
        exp_q.push_back('{1, 0, w1234, c + 47});
        n0 = 0; n1 = 0;
        for (int i = 0; i < 80 && (p0_enable_i || p1_enable_i); i++) begin
            @(negedge clk);
            if (p0_enable_i && n0 == 2) p0_enable_i = 0;
            if (p1_enable_i && n1 == 2) p1_enable_i = 0;
            if (p0_ack_o) n0++;
            if (p1_ack_o) n1++;
        end
        check("rr_p0_count", n0, 2);
        check("rr_p1_count", n1, 2);

        // Reset in cycle 5 of a port 0 read, release in cycle 7.
        repeat (2) @(negedge clk);
        p0_enable_i = 1; p0_write_i = 0; p0_addr_i = 32'h40;
        repeat (5) @(negedge clk);
        rst_i = 0;
        p0_enable_i = 0;
        #1;
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_outs", {p0_ack_o, p1_ack_o, mem_enable_o, mem_write_o, grant_o}, 0);
        check("mid_rst_p0_data", p0_data_o, 0);
        check("mid_rst_p1_data", p1_data_o, 0);
        @(negedge clk);
        rst_i = 1;
        p1_enable_i = 1; p1_write_i = 0; p1_addr_i = 32'h80;
        exp_q.push_back('{1, 0, w1234, cyc + 11});
        for (int i = 0; i < 20 && !p1_ack_o; i++) @(negedge clk);
        @(negedge clk);
        p1_enable_i = 0;

        // Spurious memory ack in IDLE, then a port 0 read held through its ack.
        @(negedge clk);
        spur = 1;
        @(negedge clk);
        spur = 0;
        check("spur_busy", busy_o, 0);
        @(negedge clk);
        check("spur_busy_after", busy_o, 0);
        run_txn(0, 0, 32'h40, '0, a5);
        @(negedge clk);
        check("no_regrant", busy_o, 0);

        repeat (30) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
